// File: rtl/trigger_word_sequencer_pkg.sv
// Shared constants and types for the trigger word sequencer.
// Holds the idle fill, the mode encoding and the trigger edge pattern.
package trigger_word_sequencer_pkg;

    localparam logic [15:0] SEQ_IDLE_FILL  = 16'hFFFF;
    localparam logic [2:0]  EDGE_PATTERN   = 3'b001;
    localparam logic [15:0] COUNT_MAX      = 16'hFFFF;
    localparam int unsigned HOLDOFF_CYCLES = 2;

    typedef enum logic {
        MODE_EXT  = 1'b0,
        MODE_SELF = 1'b1
    } seq_mode_e;

endpackage

// File: rtl/trigger_word_sequencer_edge.sv
// trigger_edge_detect: two-flop synchronizer feeding a 3-bit history register.
// edge_pulse is high while the history shows exactly one fresh high sample.
module trigger_edge_detect
    import trigger_word_sequencer_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic trigger_in,
    input  logic clear,
    output logic edge_pulse
);

    logic [1:0] sync_ff;
    logic [2:0] shift_reg;

    // Only the history register is cleared; the synchronizer keeps tracking the pin.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff   <= '0;
            shift_reg <= '0;
        end else begin
            sync_ff   <= {sync_ff[0], trigger_in};
            shift_reg <= clear ? '0 : {shift_reg[1:0], sync_ff[1]};
        end
    end

    assign edge_pulse = (shift_reg == EDGE_PATTERN);

endmodule

// File: rtl/trigger_word_sequencer.sv
// Emits pattern-table words on self-timed or external trigger events,
// one registered word per event across all enabled serializer lanes.
module trigger_word_sequencer
    import trigger_word_sequencer_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      DEPTH       = 4,
    parameter int unsigned      CHANNELS    = 2,
    parameter int unsigned      PERIOD_BITS = 27,
    parameter logic [WIDTH-1:0] IDLE_WORD   = WIDTH'(SEQ_IDLE_FILL)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        self_mode,
    input  logic [PERIOD_BITS-1:0]      period,
    input  logic                        trigger_in,
    input  logic                        pattern_we,
    input  logic [$clog2(DEPTH)-1:0]    pattern_addr,
    input  logic [WIDTH-1:0]            pattern_data,
    input  logic [CHANNELS-1:0]         channel_enable,
    output logic [CHANNELS*WIDTH-1:0]   word_out,
    output logic                        sync_out,
    output logic [15:0]                 event_count
);

    localparam int unsigned          ADDR_BITS    = $clog2(DEPTH);
    localparam logic [PERIOD_BITS-1:0] PERIOD_MIN = PERIOD_BITS'(2);
    localparam logic [1:0]           HOLDOFF_INIT = 2'(HOLDOFF_CYCLES);

    seq_mode_e              mode_now;
    seq_mode_e              mode_q;
    logic                   holding;
    logic                   mode_change;
    logic                   ext_edge;
    logic                   self_fire;
    logic                   event_fire;
    logic [PERIOD_BITS-1:0] period_cnt;
    logic [PERIOD_BITS-1:0] period_last;
    logic [ADDR_BITS-1:0]   index;
    logic [1:0]             holdoff;
    logic [WIDTH-1:0]       table_mem [DEPTH];

    trigger_edge_detect u_edge (
        .clock      (clock),
        .reset_n    (reset_n),
        .trigger_in (trigger_in),
        .clear      (mode_change),
        .edge_pulse (ext_edge)
    );

    // Mode changes are not acted on during post-reset holdoff, so the
    // unknown pre-reset mode never looks like a switch.
    always_comb begin
        mode_now    = seq_mode_e'(self_mode);
        holding     = (holdoff != '0);
        mode_change = !holding && (mode_now != mode_q);
        period_last = period - PERIOD_BITS'(1);
        self_fire   = (period >= PERIOD_MIN) && (period_cnt == period_last);
        event_fire  = !holding && !mode_change &&
                      ((mode_now == MODE_SELF) ? self_fire : ext_edge);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q  <= MODE_EXT;
            holdoff <= HOLDOFF_INIT;
        end else begin
            mode_q <= mode_now;
            if (holding) begin
                holdoff <= holdoff - 2'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt <= '0;
        end else if (holding || mode_change || (mode_now != MODE_SELF) ||
                     (period < PERIOD_MIN) || (period_cnt >= period_last)) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PERIOD_BITS'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            index <= '0;
        end else if (mode_change) begin
            index <= '0;
        end else if (event_fire) begin
            index <= index + ADDR_BITS'(1);
        end
    end

    // A write landing on the entry being emitted takes effect after the read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                table_mem[i] <= IDLE_WORD;
            end
        end else if (pattern_we) begin
            table_mem[pattern_addr] <= pattern_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_out    <= {CHANNELS{IDLE_WORD}};
            sync_out    <= 1'b0;
            event_count <= '0;
        end else begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                word_out[k*WIDTH +: WIDTH] <= (event_fire && channel_enable[k]) ?
                                              table_mem[index] : IDLE_WORD;
            end
            sync_out <= event_fire && (index == '0);
            if (event_fire && (event_count != COUNT_MAX)) begin
                event_count <= event_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_trigger_word_sequencer.sv
// Directed bench for trigger_word_sequencer with a cycle-level reference model
// and per-cycle output comparison plus literal scenario expectations.
module tb_trigger_word_sequencer;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int C  = 2;
    localparam int PB = 27;

    logic            clock = 1'b0;
    logic            reset_n = 1'b1;
    logic            self_mode = 1'b0;
    logic [PB-1:0]   period = '0;
    logic            trigger_in = 1'b0;
    logic            pattern_we = 1'b0;
    logic [1:0]      pattern_addr = '0;
    logic [W-1:0]    pattern_data = '0;
    logic [C-1:0]    channel_enable = 2'b11;
    logic [C*W-1:0]  word_out;
    logic            sync_out;
    logic [15:0]     event_count;

    trigger_word_sequencer #(
        .WIDTH       (W),
        .DEPTH       (D),
        .CHANNELS    (C),
        .PERIOD_BITS (PB)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .self_mode      (self_mode),
        .period         (period),
        .trigger_in     (trigger_in),
        .pattern_we     (pattern_we),
        .pattern_addr   (pattern_addr),
        .pattern_data   (pattern_data),
        .channel_enable (channel_enable),
        .word_out       (word_out),
        .sync_out       (sync_out),
        .event_count    (event_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: edge number since reset, trigger samples per edge,
    // and the edge at which the trigger history was last wiped.
    int          e;
    int          clear_edge;
    bit          ring [8];
    int          m_idx;
    int          m_phase;
    bit          m_prev;
    logic [7:0]  m_table [D];
    logic [15:0] exp_word;
    bit          exp_sync;
    logic [15:0] exp_count;
    bit          fire;
    bit          ext;
    int          per;

    // History bit j seen during cycle e was loaded at edge e-1-j from the
    // trigger sampled at edge e-3-j; loads at or before a wipe read as 0.
    function automatic bit hist_bit(int j);
        int ld;
        int src;
        ld  = e - 1 - j;
        src = e - 3 - j;
        if (ld <= clear_edge || src < 1) return 1'b0;
        return ring[src % 8];
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            e = 0;
            clear_edge = 0;
            m_idx = 0;
            m_phase = 0;
            m_prev = 1'b0;
            for (int i = 0; i < D; i++) m_table[i] = 8'hFF;
            exp_word = 16'hFFFF;
            exp_sync = 1'b0;
            exp_count = 16'h0000;
        end else begin
            e++;
            ext = !hist_bit(2) && !hist_bit(1) && hist_bit(0);
            per = int'(period);
            fire = 1'b0;
            if (e <= 2) begin
                m_phase = 0;
            end else if (self_mode != m_prev) begin
                m_idx = 0;
                m_phase = 0;
                clear_edge = e;
            end else if (self_mode) begin
                fire = (per >= 2) && (m_phase == per - 1);
                m_phase = (per >= 2 && m_phase < per - 1) ? m_phase + 1 : 0;
            end else begin
                fire = ext;
                m_phase = 0;
            end
            m_prev = self_mode;
            ring[e % 8] = trigger_in;
            if (fire) begin
                for (int k = 0; k < C; k++)
                    exp_word[k*8 +: 8] = channel_enable[k] ? m_table[m_idx] : 8'hFF;
                exp_sync = (m_idx == 0);
                m_idx = (m_idx + 1) % D;
                if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
            end else begin
                exp_word = 16'hFFFF;
                exp_sync = 1'b0;
            end
            if (pattern_we) m_table[pattern_addr] = pattern_data;
        end
    end

    // Every cycle: advance to the falling edge and compare against the model.
    task automatic tick();
        @(negedge clock);
        total++;
        if (word_out !== exp_word) begin
            bad++;
            $display("FAIL word_out @%0t: got %h want %h", $time, word_out, exp_word);
        end
        total++;
        if (sync_out !== exp_sync) begin
            bad++;
            $display("FAIL sync_out @%0t: got %b want %b", $time, sync_out, exp_sync);
        end
        total++;
        if (event_count !== exp_count) begin
            bad++;
            $display("FAIL event_count @%0t: got %h want %h", $time, event_count, exp_count);
        end
    endtask

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wait_word(input int limit, output int waited);
        waited = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (word_out[7:0] !== 8'hFF || sync_out === 1'b1) begin
                waited = i;
                break;
            end
        end
        if (waited < 0) begin
            total++;
            bad++;
            $display("FAIL wait_word: no word within %0d cycles", limit);
        end
    endtask

    logic [7:0] tbl [D];
    int w;
    int extra;

    initial begin
        tbl[0] = 8'h0F; tbl[1] = 8'h7E; tbl[2] = 8'h77; tbl[3] = 8'h55;
        period = PB'(10);
        #1 reset_n = 1'b0;
        repeat (3) tick();
        check("reset word", int'(word_out), 'hFFFF);
        check("reset sync", int'(sync_out), 0);
        check("reset count", int'(event_count), 0);
        reset_n = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < D; i++) begin
            pattern_we = 1'b1;
            pattern_addr = 2'(i);
            pattern_data = tbl[i];
            tick();
        end
        pattern_we = 1'b0;

        // Scenario 1: self mode, period 10
        self_mode = 1'b1;
        wait_word(20, w);
        check("s1 first latency", w, 11);
        check("s1 lane0 e0", int'(word_out[7:0]), 'h0F);
        check("s1 lane1 e0", int'(word_out[15:8]), 'h0F);
        check("s1 sync e0", int'(sync_out), 1);
        for (int k = 1; k < D; k++) begin
            wait_word(20, w);
            check("s1 spacing", w, 10);
            check("s1 lane0 word", int'(word_out[7:0]), int'(tbl[k]));
            check("s1 sync off", int'(sync_out), 0);
        end

        // Scenario 3: lane 1 disabled during an event
        channel_enable = 2'b01;
        wait_word(20, w);
        check("s3 lane0", int'(word_out[7:0]), 'h0F);
        check("s3 lane1 idle", int'(word_out[15:8]), 'hFF);
        check("s3 sync", int'(sync_out), 1);
        channel_enable = 2'b11;

        // Scenario 4: overwrite entry 1 in its own event cycle
        repeat (9) tick();
        pattern_we = 1'b1;
        pattern_addr = 2'd1;
        pattern_data = 8'hAA;
        tick();
        pattern_we = 1'b0;
        check("s4 old entry", int'(word_out[7:0]), 'h7E);
        check("s4 old entry lane1", int'(word_out[15:8]), 'h7E);
        repeat (3) wait_word(20, w);
        wait_word(20, w);
        check("s4 new entry", int'(word_out[7:0]), 'hAA);

        // Scenario 2: external trigger, 5 high samples, 2 low, high again
        self_mode = 1'b0;
        repeat (3) tick();
        trigger_in = 1'b1;
        wait_word(10, w);
        check("s2 latency", w, 4);
        check("s2 entry0", int'(word_out[7:0]), 'h0F);
        check("s2 sync", int'(sync_out), 1);
        extra = 0;
        tick();
        if (word_out[7:0] !== 8'hFF) extra++;
        trigger_in = 1'b0;
        repeat (2) begin
            tick();
            if (word_out[7:0] !== 8'hFF) extra++;
        end
        check("s2 single word", extra, 0);
        trigger_in = 1'b1;
        wait_word(10, w);
        trigger_in = 1'b0;
        check("s2 second latency", w, 4);
        check("s2 entry1", int'(word_out[7:0]), 'hAA);

        // Scenario 5: asynchronous reset at index 2 while a word is showing
        #2 reset_n = 1'b0;
        #1;
        check("s5 async word", int'(word_out), 'hFFFF);
        check("s5 async count", int'(event_count), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        trigger_in = 1'b1;
        wait_word(10, w);
        trigger_in = 1'b0;
        check("s5 latency", w, 4);
        check("s5 sync", int'(sync_out), 1);
        check("s5 idle entry0", int'(word_out[7:0]), 'hFF);
        check("s5 count", int'(event_count), 1);

        // Scenario 6: period 0/1 silent, then saturate at period 2
        self_mode = 1'b1;
        period = '0;
        repeat (40) tick();
        check("s6 period0 count", int'(event_count), 1);
        period = PB'(1);
        repeat (20) tick();
        check("s6 period1 count", int'(event_count), 1);
        period = PB'(2);
        for (int i = 0; i < 140000 && event_count != 16'hFFFF; i++) tick();
        check("s6 saturated", int'(event_count), 'hFFFF);
        repeat (20) tick();
        check("s6 held", int'(event_count), 'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
